// File: rtl/mul32_pkg.sv
// Shared types and constants for the sequential multiply-add engine.
package mul32_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
   localparam int QW   = 32;
   localparam int CNTW = 5;
endpackage

// File: rtl/mul32_step.sv
// One radix-2 shift-add step: conditionally add multiplicand, then shift both operands.
module mul32_step
   import mul32_pkg::*;
#(
   parameter int K = 32
) (
   input  logic [K+QW-1:0] acc_i,
   input  logic [K+QW-1:0] mcand_i,
   input  logic [QW-1:0]   mplier_i,
   output logic [K+QW-1:0] acc_o,
   output logic [K+QW-1:0] mcand_o,
   output logic [QW-1:0]   mplier_o
);

   // Sum never exceeds 2^(K+32)-1, so the dropped carry-out is always zero.
   assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
   assign mcand_o  = mcand_i << 1;
   assign mplier_o = mplier_i >> 1;

endmodule

// File: rtl/mul32_seq.sv
// Sequential x = q*d + r, one multiplier bit per cycle, valid/ready on both sides.
// Optional MUL32_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul32_seq
   import mul32_pkg::*;
#(
   parameter int K = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [QW-1:0]     q,
   input  logic [K-1:0]      d,
   input  logic [K-1:0]      r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [K+QW-1:0]   x,
   output logic              busy
);

   mul_state_t          state_q, state_d;
   logic [K+QW-1:0]     acc_q, acc_d, mcand_q, mcand_d;
   logic [QW-1:0]       mplier_q, mplier_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [K+QW-1:0]     acc_nx, mcand_nx;
   logic [QW-1:0]       mplier_nx;
   logic                last_step;

   mul32_step #(.K(K)) u_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (acc_nx),
      .mcand_o  (mcand_nx),
      .mplier_o (mplier_nx)
   );

`ifdef MUL32_SEQ_EARLY_EXIT_EN
   assign last_step = (cnt_q == CNTW'(QW-1)) || (mplier_q[QW-1:1] == '0);
`else
   assign last_step = (cnt_q == CNTW'(QW-1));
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d    = {{QW{1'b0}}, r};
               mcand_d  = {{QW{1'b0}}, d};
               mplier_d = q;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            acc_d    = acc_nx;
            mcand_d  = mcand_nx;
            mplier_d = mplier_nx;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign x         = acc_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed and randomized checks of mul32_seq (K=32); latency expectation follows MUL32_SEQ_EARLY_EXIT_EN.
module tb_mul32_seq;
   localparam int K = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0]   q;
   logic [K-1:0]  d, r;
   logic [K+31:0] x;

   int n_tests = 0;
   int n_fail  = 0;

   mul32_seq #(.K(K)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q         (q),
      .d         (d),
      .r         (r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x         (x),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] qv);
      int l;
`ifdef MUL32_SEQ_EARLY_EXIT_EN
      l = 1;
      for (int i = 0; i < 32; i++) if (qv[i]) l = i + 1;
`else
      l = 32;
`endif
      return l;
   endfunction

   // Issue one op, measure latency, optionally stall the consumer and poke in_valid mid-op.
   task automatic run_op(input string tag, input logic [31:0] qv, input logic [31:0] dv,
                         input logic [31:0] rv, input logic [63:0] exp_x, input int hold,
                         input bit pulse, input bit chk_lat);
      int lat;
      @(negedge clk);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      q = qv; d = dv; r = rv; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      q = ~qv; d = ~dv; r = ~rv;
      lat = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (pulse && lat == 3) begin
            in_valid = 1'b1; q = 32'hDEAD_BEEF; d = 32'h1357_9BDF; r = 32'h0BAD_F00D;
         end else if (pulse && lat == 4) begin
            in_valid = 1'b0;
         end
      end while (!out_valid && lat < 100);
      in_valid = 1'b0;
      chk({tag, ".done"}, 64'(out_valid), 64'd1);
      if (chk_lat) chk({tag, ".latency"}, 64'(lat), 64'(exp_lat(qv)));
      chk({tag, ".x"}, x, exp_x);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, ".hold_x"}, x, exp_x);
         chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ".released"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] rq, rd, rr;
      logic [63:0] ref_x;
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; q = '0; d = '0; r = '0;
      repeat (2) @(negedge clk);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.x", x, 64'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst.in_ready", 64'(in_ready), 64'd1);

      run_op("basic", 32'd7, 32'd6, 32'd5, 64'd47, 0, 1'b0, 1'b1);
      run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 0, 1'b0, 1'b1);
      run_op("dzero", 32'h0000_5555, 32'd0, 32'h1234, 64'h1234, 0, 1'b0, 1'b1);
      run_op("qzero", 32'd0, 32'd77, 32'd9, 64'd9, 0, 1'b0, 1'b1);
      run_op("stall", 32'd100, 32'd200, 32'd3, 64'd20003, 5, 1'b1, 1'b1);
      run_op("q1", 32'd1, 32'd9, 32'd2, 64'd11, 0, 1'b0, 1'b1);
      run_op("qmsb", 32'h8000_0000, 32'd1, 32'd0, 64'h8000_0000, 0, 1'b0, 1'b1);
      run_op("mixed", 32'h0001_0000, 32'hABCD_0123, 32'hFFFF_FFFF, 64'h0000_ABCD_0123_0000 + 64'hFFFF_FFFF,
             0, 1'b0, 1'b1);

      // Reset while busy: everything drops immediately, no clock needed.
      @(negedge clk);
      q = 32'hFFFF_0000; d = 32'h1234_5678; r = 32'd1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("midrst.busy", 64'(busy), 64'd0);
      chk("midrst.out_valid", 64'(out_valid), 64'd0);
      chk("midrst.x", x, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      run_op("postrst", 32'd3, 32'd4, 32'd1, 64'd13, 0, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         rq = $urandom;
         rd = $urandom;
         rr = $urandom;
         if (i % 4 == 1) rq = rq >> $urandom_range(31, 0);
         ref_x = 64'(rq) * 64'(rd) + 64'(rr);
         run_op("rand", rq, rd, rr, ref_x, int'($urandom_range(3, 0)), 1'(i % 7 == 0), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
